issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

Register-hazard scoreboard and issue controller between the decode stage and execute. Tracks destination registers of outstanding long-latency operations (multiply/divide, completing via the long writeback path) and stalls decode on RAW or WAW hazards against them. Caps the number of in-flight long operations. Serialises instructions flagged by decode (CSR/fence class) by draining all long operations before issue and holding until they complete.

## Interface
- NREG, 32: architectural registers; x0 is never tracked.
- MAX_LONG, 4: maximum long operations in flight.
- CNTW, 3: width of the in-flight counter; must hold MAX_LONG.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; low = in reset.
- dec_valid  in  1  decode presents an instruction.
- dec_rs1 / dec_rs2  in  5 each  source register indices.
- dec_rs1_used / dec_rs2_used  in  1 each  source actually read.
- dec_rd  in  5  destination index.
- dec_rd_wr  in  1  instruction writes rd.
- dec_long  in  1  instruction is long-latency.
- dec_serial  in  1  instruction must issue serialised.
- dec_retry  out  1  decode must hold its instruction this cycle.
- issue_valid  out  1  instruction accepted by execute this cycle.
- exe_retry  in  1  execute cannot accept this cycle.
- wb_valid  in  1  execute writeback this cycle.
- wb_long  in  1  the writeback is a long-op completion.
- wb_rd  in  5  writeback destination.
- busy_mask  out  NREG  pending-write bit per register; bit 0 always 0.
- long_count  out  CNTW  long ops in flight.
- sb_error  out  1  sticky protocol-violation flag.

## Operation
- States: RUN, DRAIN, SERIAL.
- A source hazard exists when the source is used, its index is nonzero, and busy_mask[index] = 1.
- A WAW hazard exists when dec_rd_wr = 1, dec_rd != 0, and busy_mask[dec_rd] = 1.
- A cap hazard exists when dec_long = 1 and long_count = MAX_LONG.
- Hazards use registered state only. There is no same-cycle bypass from writeback.
- issue_valid = dec_valid & !exe_retry & state==RUN & no hazard & (!dec_serial | long_count==0).
- dec_retry = dec_valid & !issue_valid.
- RUN:
  - A serial instruction with long_count != 0 moves the FSM to DRAIN; the instruction is not issued.
  - A serial instruction that issues moves the FSM to SERIAL.
- DRAIN:
  - No issue.
  - Moves to RUN once long_count == 0, evaluated on the registered value.
  - The serial instruction issues in RUN on the following cycle.
- SERIAL:
  - No issue.
  - Moves to RUN on the cycle wb_valid=1 & wb_long=0, which is the serial op's own result.
- Issuing a long op:
  - long_count increments.
  - If dec_rd_wr=1 and dec_rd != 0, busy_mask[dec_rd] is set.
- A wb_valid & wb_long completion:
  - long_count decrements.
  - If wb_rd != 0, busy_mask[wb_rd] is cleared.
- A long issue and a long completion in the same cycle leave the count unchanged; both mask updates still apply.
- A same-index set and clear cannot occur, because the WAW check prevents it.
- Short-op writebacks never touch busy_mask or long_count.
- sb_error is set and held until reset on either violation:
  - wb_long completion with long_count == 0; the count stays 0.
  - wb_long completion to a nonzero wb_rd whose busy bit is 0.

## Timing
- Reset values: busy_mask 0, long_count 0, state RUN, sb_error 0.
- While reset is low: issue_valid = 0 and dec_retry = dec_valid.
- issue_valid and dec_retry are combinational from the inputs and registered state, within the same cycle.
- Mask and count updates are visible on the cycle after the edge.
- A RAW-dependent instruction waiting on register r issues no earlier than the cycle after the wb_long that clears r.
- Leaving DRAIN or SERIAL costs one cycle: the transition edge comes first, then issue.
- Reset asserted mid-operation clears all state immediately. Completions that arrive later for pre-reset ops set sb_error.

## Test plan
- Issue long op with rd=5; next cycle present an op using rs1=5 → dec_retry=1 until wb_long with wb_rd=5; issue_valid=1 on the following cycle; busy_mask goes 0x20 → 0.
- Issue 4 long ops (rd=1..4) back-to-back, then present a 5th long op → 5th held, long_count=4. Complete rd=2 → 5th issues the next cycle, count back to 4.
- Issue a long op and complete another long op in the same cycle → long_count unchanged; both mask bits correct.
- Serial op with long_count=2 → state DRAIN, dec_retry=1. Complete both → RUN, serial issues, state SERIAL. Short wb → RUN; the next op issues one cycle later.
- wb_long with count 0, or to a non-busy rd=7 → sb_error=1 and stays 1; a long op with rd=0 counts but sets no mask bit.
- Assert reset low mid-DRAIN with count 3 → all outputs at reset values asynchronously; issue_valid=0 while reset is low.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard and issue controller between decode and execute.
// Tracks long-latency destinations, caps in-flight long ops and serialises CSR/fence-class instructions.
module issue_scoreboard #(
  parameter int NREG     = 32,
  parameter int MAX_LONG = 4,
  parameter int CNTW     = 3,
  localparam int RW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dec_valid,
  input  logic [RW-1:0]   dec_rs1,
  input  logic [RW-1:0]   dec_rs2,
  input  logic            dec_rs1_used,
  input  logic            dec_rs2_used,
  input  logic [RW-1:0]   dec_rd,
  input  logic            dec_rd_wr,
  input  logic            dec_long,
  input  logic            dec_serial,
  output logic            dec_retry,
  output logic            issue_valid,
  input  logic            exe_retry,
  input  logic            wb_valid,
  input  logic            wb_long,
  input  logic [RW-1:0]   wb_rd,
  output logic [NREG-1:0] busy_mask,
  output logic [CNTW-1:0] long_count,
  output logic            sb_error
);

  typedef enum logic [1:0] {RUN, DRAIN, SERIAL} state_t;

  state_t          state_q, state_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic haz_rs1, haz_rs2, haz_waw, haz_cap, hazard;
  logic cnt_zero, long_issue, long_wb;

  // Hazards look only at registered state; a writeback this cycle does not unblock decode.
  assign cnt_zero = (cnt_q == '0);
  assign haz_rs1  = dec_rs1_used && (dec_rs1 != '0) && busy_q[dec_rs1];
  assign haz_rs2  = dec_rs2_used && (dec_rs2 != '0) && busy_q[dec_rs2];
  assign haz_waw  = dec_rd_wr && (dec_rd != '0) && busy_q[dec_rd];
  assign haz_cap  = dec_long && (cnt_q == CNTW'(MAX_LONG));
  assign hazard   = haz_rs1 || haz_rs2 || haz_waw || haz_cap;

  assign long_issue = issue_valid && dec_long;
  assign long_wb    = wb_valid && wb_long;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      // NOTE: busy_mask is a flop vector, not a RAM, so a full reset is cheap and required.
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through this block infers a latch.
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (dec_valid && dec_serial && !cnt_zero) state_d = DRAIN;
        else if (issue_valid && dec_serial)       state_d = SERIAL;
      end
      DRAIN:   if (cnt_zero) state_d = RUN;
      SERIAL:  if (wb_valid && !wb_long) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    issue_valid = reset && dec_valid && !exe_retry && (state_q == RUN) && !hazard &&
                  (!dec_serial || cnt_zero);
    dec_retry   = dec_valid && !issue_valid;
  end

  // Count, mask and sticky error bookkeeping; an underflowing completion leaves the count at zero.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    err_d  = err_q;
    unique case ({long_issue, long_wb && !cnt_zero})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (long_issue && dec_rd_wr && (dec_rd != '0)) busy_d[dec_rd] = 1'b1;
    if (long_wb && (wb_rd != '0))                  busy_d[wb_rd]  = 1'b0;
    if (long_wb && (cnt_zero || ((wb_rd != '0) && !busy_q[wb_rd]))) err_d = 1'b1;
  end

  assign busy_mask  = busy_q;
  assign long_count = cnt_q;
  assign sb_error   = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: per-step expectations go through a scoreboard queue
// and are checked against the DUT on the falling edge.
module tb_issue_scoreboard;

  logic        clk, reset;
  logic        dec_valid, dec_rs1_used, dec_rs2_used, dec_rd_wr, dec_long, dec_serial;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic        dec_retry, issue_valid, exe_retry, wb_valid, wb_long;
  logic [31:0] busy_mask;
  logic [2:0]  long_count;
  logic        sb_error;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct packed {
    logic        iv;
    logic        dr;
    logic [31:0] mask;
    logic [2:0]  cnt;
    logic        err;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  issue_scoreboard dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_rd_wr(dec_rd_wr), .dec_long(dec_long), .dec_serial(dec_serial),
    .dec_retry(dec_retry), .issue_valid(issue_valid), .exe_retry(exe_retry),
    .wb_valid(wb_valid), .wb_long(wb_long), .wb_rd(wb_rd),
    .busy_mask(busy_mask), .long_count(long_count), .sb_error(sb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
    dec_rd = 0; dec_rd_wr = 0; dec_long = 0; dec_serial = 0;
    exe_retry = 0; wb_valid = 0; wb_long = 0; wb_rd = 0;
  endtask

  task automatic dec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic wr, input logic lng, input logic ser);
    dec_valid = 1; dec_rs1 = rs1; dec_rs1_used = u1; dec_rs2 = rs2; dec_rs2_used = u2;
    dec_rd = rd; dec_rd_wr = wr; dec_long = lng; dec_serial = ser;
  endtask

  task automatic wb(input logic lng, input logic [4:0] rd);
    wb_valid = 1; wb_long = lng; wb_rd = rd;
  endtask

  task automatic check_field(input string tag, input string fld,
                             input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
    end
  endtask

  // Push the expected outputs for the cycle being driven, pop and compare at the falling edge.
  task automatic step(input string tag, input logic iv, input logic dr,
                      input logic [31:0] mask, input logic [2:0] cnt, input logic err);
    exp_t  e;
    string t;
    exp_q.push_back('{iv: iv, dr: dr, mask: mask, cnt: cnt, err: err});
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_field(t, "issue_valid", {31'd0, issue_valid}, {31'd0, e.iv});
    check_field(t, "dec_retry",   {31'd0, dec_retry},   {31'd0, e.dr});
    check_field(t, "busy_mask",   busy_mask,            e.mask);
    check_field(t, "long_count",  {29'd0, long_count},  {29'd0, e.cnt});
    check_field(t, "sb_error",    {31'd0, sb_error},    {31'd0, e.err});
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    reset = 0;
    // Reset held: issue blocked, retry follows dec_valid.
    dec(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0);
    step("rst_hold", 0, 1, 32'h0, 3'd0, 0);
    reset = 1;

    // RAW wait on r5 with no writeback bypass.
    dec(5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);
    step("raw_issue_long", 1, 0, 32'h0, 3'd0, 0);
    dec(5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0);
    step("raw_hold", 0, 1, 32'h20, 3'd1, 0);
    dec(5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0); wb(1, 5'd5);
    step("raw_no_bypass", 0, 1, 32'h20, 3'd1, 0);
    dec(5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0);
    step("raw_release", 1, 0, 32'h0, 3'd0, 0);
    step("raw_idle", 0, 0, 32'h0, 3'd0, 0);

    // Cap: four long ops, fifth waits until one completes.
    dec(5'd0, 0, 5'd0, 0, 5'd1, 1, 1, 0); step("cap_l1", 1, 0, 32'h0,  3'd0, 0);
    dec(5'd0, 0, 5'd0, 0, 5'd2, 1, 1, 0); step("cap_l2", 1, 0, 32'h2,  3'd1, 0);
    dec(5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 0); step("cap_l3", 1, 0, 32'h6,  3'd2, 0);
    dec(5'd0, 0, 5'd0, 0, 5'd4, 1, 1, 0); step("cap_l4", 1, 0, 32'hE,  3'd3, 0);
    dec(5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0); step("cap_full", 0, 1, 32'h1E, 3'd4, 0);
    dec(5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0); wb(1, 5'd2);
    step("cap_wb_same", 0, 1, 32'h1E, 3'd4, 0);
    dec(5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0); step("cap_release", 1, 0, 32'h1A, 3'd3, 0);
    step("cap_after", 0, 0, 32'h5A, 3'd4, 0);

    // Simultaneous long issue and long completion.
    wb(1, 5'd1);                          step("sim_pre_wb", 0, 0, 32'h5A, 3'd4, 0);
    dec(5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0); wb(1, 5'd3);
    step("sim_both", 1, 0, 32'h58, 3'd3, 0);
    step("sim_after", 0, 0, 32'h250, 3'd3, 0);

    // Serial op: drain two long ops, issue, hold in SERIAL until a short writeback.
    wb(1, 5'd4);                          step("ser_pre", 0, 0, 32'h250, 3'd3, 0);
    dec(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1); step("ser_to_drain", 0, 1, 32'h240, 3'd2, 0);
    dec(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1); wb(1, 5'd6);
    step("ser_drain1", 0, 1, 32'h240, 3'd2, 0);
    dec(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1); wb(1, 5'd9);
    step("ser_drain2", 0, 1, 32'h200, 3'd1, 0);
    dec(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1); step("ser_drain_exit", 0, 1, 32'h0, 3'd0, 0);
    dec(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1); step("ser_issue", 1, 0, 32'h0, 3'd0, 0);
    dec(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0); step("ser_hold", 0, 1, 32'h0, 3'd0, 0);
    dec(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0); wb(0, 5'd0);
    step("ser_short_wb", 0, 1, 32'h0, 3'd0, 0);
    dec(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0); step("ser_next", 1, 0, 32'h0, 3'd0, 0);

    // Protocol errors: completion with count zero, then to a non-busy register.
    wb(1, 5'd0);                          step("err_underflow", 0, 0, 32'h0, 3'd0, 0);
    step("err_sticky", 0, 0, 32'h0, 3'd0, 1);
    reset = 0; #1; reset = 1;
    step("err_cleared", 0, 0, 32'h0, 3'd0, 0);
    dec(5'd0, 0, 5'd0, 0, 5'd1, 1, 1, 0); step("err_l1", 1, 0, 32'h0, 3'd0, 0);
    wb(1, 5'd7);                          step("err_nonbusy", 0, 0, 32'h2, 3'd1, 0);
    dec(5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0); step("rd0_long", 1, 0, 32'h2, 3'd0, 1);
    step("rd0_after", 0, 0, 32'h2, 3'd1, 1);

    // Reset asserted mid-DRAIN with three long ops outstanding.
    dec(5'd0, 0, 5'd0, 0, 5'd10, 1, 1, 0); step("rst_l10", 1, 0, 32'h2,   3'd1, 1);
    dec(5'd0, 0, 5'd0, 0, 5'd11, 1, 1, 0); step("rst_l11", 1, 0, 32'h402, 3'd2, 1);
    dec(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);  step("rst_drain", 0, 1, 32'hC02, 3'd3, 1);
    dec(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
    reset = 0;
    step("rst_async", 0, 1, 32'h0, 3'd0, 0);
    dec(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    step("rst_low_issue", 0, 1, 32'h0, 3'd0, 0);
    reset = 1;
    wb(1, 5'd10);                          step("rst_stale_wb", 0, 0, 32'h0, 3'd0, 0);
    step("rst_stale_err", 0, 0, 32'h0, 3'd0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
